// File: rtl/feature_seq_pkg.sv
// Shared types, register map and field positions for the feature buffer read sequencer.
package feature_seq_pkg;

  localparam int unsigned DEPTH_DEF = 400;
  localparam int unsigned LW        = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_STATUS = 3'd1;
  localparam logic [2:0] REG_BASE   = 3'd2;
  localparam logic [2:0] REG_LEN    = 3'd3;
  localparam logic [2:0] REG_COUNT  = 3'd4;

  localparam int unsigned CTRL_START  = 0;
  localparam int unsigned CTRL_ABORT  = 1;
  localparam int unsigned CTRL_IRQ_EN = 2;

  localparam int unsigned ST_BUSY    = 0;
  localparam int unsigned ST_DONE    = 1;
  localparam int unsigned ST_ERR     = 2;
  localparam int unsigned ST_ABORTED = 3;

  function automatic logic [31:0] be_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/seq_skid_fifo.sv
// Small synchronous FIFO carrying stream data plus its LAST tag; head entry drives the stream.
module seq_skid_fifo #(
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned OW   = $clog2(DEPTH + 1),
  localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          i_push,
  input  logic [DW-1:0] i_data,
  input  logic          i_last,
  input  logic          i_pop,
  input  logic          i_flush,
  output logic [DW-1:0] o_data,
  output logic          o_last,
  output logic          o_valid,
  output logic [OW-1:0] o_occ
);

  logic [DW-1:0] r_data [DEPTH];
  logic          r_last [DEPTH];
  logic [PW-1:0] r_wptr, r_rptr;
  logic [OW-1:0] r_occ;
  logic          w_pop, w_push;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_valid = (r_occ != '0);
  assign w_pop   = i_pop & o_valid;
  assign w_push  = i_push & ((r_occ != OW'(DEPTH)) | w_pop);
  assign o_data  = r_data[r_rptr];
  assign o_last  = r_last[r_rptr] & o_valid;
  assign o_occ   = r_occ;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_data[i] <= '0;
        r_last[i] <= 1'b0;
      end
      r_wptr <= '0;
      r_rptr <= '0;
      r_occ  <= '0;
    end else if (i_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_occ  <= '0;
    end else begin
      if (w_push) begin
        r_data[r_wptr] <= i_data;
        r_last[r_wptr] <= i_last;
        r_wptr         <= nxt(r_wptr);
      end
      if (w_pop) r_rptr <= nxt(r_rptr);
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase
    end
  end

endmodule

// File: rtl/feature_buf_sequencer.sv
// Host-programmed sequencer: streams feature buffer words BASE..BASE+LEN-1 to the compute stage.
module feature_buf_sequencer
  import feature_seq_pkg::*;
#(
  parameter int unsigned DEPTH      = DEPTH_DEF,
  parameter int unsigned AW         = 9,
  parameter int unsigned DW         = 32,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          AVL_CS,
  input  logic          AVL_READ,
  input  logic          AVL_WRITE,
  input  logic [3:0]    AVL_BYTE_EN,
  input  logic [2:0]    AVL_ADDR,
  input  logic [31:0]   AVL_WRITEDATA,
  output logic [31:0]   AVL_READDATA,
  output logic          MEM_RD,
  output logic [AW-1:0] MEM_ADDR,
  input  logic [DW-1:0] MEM_RDATA,
  output logic [DW-1:0] OUT_DATA,
  output logic          OUT_VALID,
  output logic          OUT_LAST,
  input  logic          OUT_READY,
  output logic          IRQ
);

  localparam int unsigned OW = $clog2(FIFO_DEPTH + 1);

  state_t        r_state, w_state_nxt;
  logic          r_irq_en, r_done, r_err, r_aborted;
  logic [AW-1:0] r_base;
  logic [LW-1:0] r_len, r_count, r_issued;
  logic          r_inflight, r_inflight_last;

  logic [31:0]   w_wmask;
  logic          w_wr, w_wr_ctrl, w_wr_status, w_wr_base, w_wr_len;
  logic          w_start, w_abort, w_busy, w_abort_run, w_start_idle;
  logic [LW:0]   w_end;
  logic          w_range_ok, w_pop, w_credit, w_issue, w_done_set;
  logic [3:0]    w_st_w1c;
  logic [OW-1:0] w_occ;
  logic          w_unused;

  assign w_wmask     = be_mask(AVL_BYTE_EN);
  assign w_wr        = AVL_CS & AVL_WRITE;
  assign w_wr_ctrl   = w_wr & (AVL_ADDR == REG_CTRL);
  assign w_wr_status = w_wr & (AVL_ADDR == REG_STATUS);
  assign w_busy      = (r_state != IDLE);
  assign w_wr_base   = w_wr & (AVL_ADDR == REG_BASE) & ~w_busy;
  assign w_wr_len    = w_wr & (AVL_ADDR == REG_LEN) & ~w_busy;

  assign w_start      = w_wr_ctrl & AVL_WRITEDATA[CTRL_START] & w_wmask[CTRL_START];
  assign w_abort      = w_wr_ctrl & AVL_WRITEDATA[CTRL_ABORT] & w_wmask[CTRL_ABORT];
  assign w_abort_run  = w_abort & w_busy;
  assign w_start_idle = w_start & ~w_abort & ~w_busy;
  assign w_st_w1c     = AVL_WRITEDATA[3:0] & w_wmask[3:0] & {4{w_wr_status}};

  assign w_end      = (LW + 1)'(r_base) + (LW + 1)'(r_len);
  assign w_range_ok = (r_len != '0) && (w_end <= (LW + 1)'(DEPTH));

  // Credit counts FIFO entries plus the read in flight, so pushes never need back-pressure.
  assign w_pop    = OUT_VALID & OUT_READY;
  assign w_credit = (32'(w_occ) + 32'(r_inflight)) < (32'(FIFO_DEPTH) + 32'(w_pop));
  assign w_issue  = (r_state == RUN) & (r_issued != r_len) & w_credit & ~w_abort;

  assign MEM_RD   = w_issue;
  assign MEM_ADDR = r_base + r_issued[AW-1:0];
  assign IRQ      = r_done & r_irq_en;

  assign w_done_set = (r_state == DRAIN) & ~w_abort & (r_count == r_len);
  assign w_unused   = &{1'b0, AVL_WRITEDATA[31:LW], w_wmask[31:LW]};

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_start_idle && w_range_ok) w_state_nxt = RUN;
      RUN:     if (w_abort) w_state_nxt = IDLE;
               else if (r_issued == r_len) w_state_nxt = DRAIN;
      DRAIN:   if (w_abort || (r_count == r_len)) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state         <= IDLE;
      r_irq_en        <= 1'b0;
      r_done          <= 1'b0;
      r_err           <= 1'b0;
      r_aborted       <= 1'b0;
      r_base          <= '0;
      r_len           <= '0;
      r_count         <= '0;
      r_issued        <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_inflight      <= w_issue;
      r_inflight_last <= w_issue & (r_issued == r_len - 1'b1);
      if (w_issue) r_issued <= r_issued + 1'b1;

      if (w_wr_ctrl && w_wmask[CTRL_IRQ_EN]) r_irq_en <= AVL_WRITEDATA[CTRL_IRQ_EN];
      if (w_wr_base) r_base <= (r_base & ~w_wmask[AW-1:0]) | (AVL_WRITEDATA[AW-1:0] & w_wmask[AW-1:0]);
      if (w_wr_len)  r_len  <= (r_len & ~w_wmask[LW-1:0]) | (AVL_WRITEDATA[LW-1:0] & w_wmask[LW-1:0]);

      if (w_st_w1c[ST_DONE])    r_done    <= 1'b0;
      if (w_st_w1c[ST_ERR])     r_err     <= 1'b0;
      if (w_st_w1c[ST_ABORTED]) r_aborted <= 1'b0;

      if (w_done_set)  r_done    <= 1'b1;
      if (w_abort_run) r_aborted <= 1'b1;
      if (w_pop && !w_abort_run) r_count <= r_count + 1'b1;

      // Starting a run clears the previous run's sticky status and progress.
      if (w_start_idle) begin
        if (w_range_ok) begin
          r_count   <= '0;
          r_issued  <= '0;
          r_done    <= 1'b0;
          r_err     <= 1'b0;
          r_aborted <= 1'b0;
        end else begin
          r_err <= 1'b1;
        end
      end
    end
  end

  seq_skid_fifo #(
    .DW    (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK     (CLK),
    .RESET   (RESET),
    .i_push  (r_inflight),
    .i_data  (MEM_RDATA),
    .i_last  (r_inflight_last),
    .i_pop   (OUT_READY),
    .i_flush (w_abort_run),
    .o_data  (OUT_DATA),
    .o_last  (OUT_LAST),
    .o_valid (OUT_VALID),
    .o_occ   (w_occ)
  );

  always_comb begin
    AVL_READDATA = '0;
    if (AVL_CS && AVL_READ) begin
      case (AVL_ADDR)
        REG_CTRL:   AVL_READDATA[CTRL_IRQ_EN] = r_irq_en;
        REG_STATUS: AVL_READDATA[3:0] = {r_aborted, r_err, r_done, w_busy};
        REG_BASE:   AVL_READDATA[AW-1:0] = r_base;
        REG_LEN:    AVL_READDATA[LW-1:0] = r_len;
        REG_COUNT:  AVL_READDATA[LW-1:0] = r_count;
        default:    AVL_READDATA = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_feature_buf_sequencer.sv
// Directed bench for feature_buf_sequencer with a 1-cycle-latency buffer model and beat monitor.
module tb_feature_buf_sequencer;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        AVL_CS, AVL_READ, AVL_WRITE;
  logic [3:0]  AVL_BYTE_EN;
  logic [2:0]  AVL_ADDR;
  logic [31:0] AVL_WRITEDATA, AVL_READDATA;
  logic        MEM_RD;
  logic [8:0]  MEM_ADDR;
  logic [31:0] MEM_RDATA = '0;
  logic [31:0] OUT_DATA;
  logic        OUT_VALID, OUT_LAST, OUT_READY, IRQ;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [0:511];
  logic [31:0] beat_data[$];
  logic        beat_last[$];
  int          rd_cnt = 0;

  always #5 CLK = ~CLK;

  feature_buf_sequencer #(
    .DEPTH      (400),
    .AW         (9),
    .DW         (32),
    .FIFO_DEPTH (2)
  ) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .AVL_CS        (AVL_CS),
    .AVL_READ      (AVL_READ),
    .AVL_WRITE     (AVL_WRITE),
    .AVL_BYTE_EN   (AVL_BYTE_EN),
    .AVL_ADDR      (AVL_ADDR),
    .AVL_WRITEDATA (AVL_WRITEDATA),
    .AVL_READDATA  (AVL_READDATA),
    .MEM_RD        (MEM_RD),
    .MEM_ADDR      (MEM_ADDR),
    .MEM_RDATA     (MEM_RDATA),
    .OUT_DATA      (OUT_DATA),
    .OUT_VALID     (OUT_VALID),
    .OUT_LAST      (OUT_LAST),
    .OUT_READY     (OUT_READY),
    .IRQ           (IRQ)
  );

  always @(posedge CLK) if (MEM_RD) MEM_RDATA <= mem[MEM_ADDR];

  always @(negedge CLK) begin
    if (OUT_VALID && OUT_READY) begin
      beat_data.push_back(OUT_DATA);
      beat_last.push_back(OUT_LAST);
    end
    if (MEM_RD) rd_cnt++;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic avl_wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
    AVL_CS = 1'b1; AVL_WRITE = 1'b1; AVL_ADDR = a; AVL_WRITEDATA = d; AVL_BYTE_EN = be;
    tick();
    AVL_CS = 1'b0; AVL_WRITE = 1'b0; AVL_BYTE_EN = 4'h0;
  endtask

  task automatic check_reg(input string tag, input logic [2:0] a, input logic [31:0] exp);
    logic [31:0] d;
    AVL_CS = 1'b1; AVL_READ = 1'b1; AVL_ADDR = a;
    #1;
    d = AVL_READDATA;
    AVL_CS = 1'b0; AVL_READ = 1'b0;
    check(tag, d, exp);
  endtask

  task automatic wait_beats(input string tag, input int base, input int n, input int budget);
    int k;
    k = 0;
    while ((beat_data.size() - base) < n && k < budget) begin
      tick();
      k++;
    end
    check(tag, beat_data.size() - base, n);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    logic [31:0] d;
    int k;
    k = 0;
    d = 32'h1;
    while (d[0] && k < budget) begin
      tick();
      AVL_CS = 1'b1; AVL_READ = 1'b1; AVL_ADDR = 3'd1;
      #1;
      d = AVL_READDATA;
      AVL_CS = 1'b0; AVL_READ = 1'b0;
      k++;
    end
    check(tag, {31'd0, d[0]}, 32'd0);
  endtask

  task automatic check_run(input string tag, input int base, input int n, input logic [31:0] first);
    for (int i = 0; i < n; i++) begin
      check({tag, "_data"}, beat_data[base + i], first + 32'(i));
      check({tag, "_last"}, {31'd0, beat_last[base + i]}, (i == n - 1) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bb;
    int r0;

    for (int i = 0; i < 512; i++) mem[i] = 32'h100 + 32'(i);
    RESET = 1'b1; AVL_CS = 1'b0; AVL_READ = 1'b0; AVL_WRITE = 1'b0;
    AVL_BYTE_EN = 4'h0; AVL_ADDR = 3'd0; AVL_WRITEDATA = '0; OUT_READY = 1'b1;
    tick(); tick(); tick();
    RESET = 1'b0;

    // reset state
    check("rst_mem_rd", {31'd0, MEM_RD}, 32'd0);
    check("rst_valid", {31'd0, OUT_VALID}, 32'd0);
    check("rst_last", {31'd0, OUT_LAST}, 32'd0);
    check("rst_data", OUT_DATA, 32'd0);
    check("rst_irq", {31'd0, IRQ}, 32'd0);
    check_reg("rst_ctrl", 3'd0, 32'd0);
    check_reg("rst_status", 3'd1, 32'd0);
    check_reg("rst_base", 3'd2, 32'd0);
    check_reg("rst_len", 3'd3, 32'd0);
    check_reg("rst_count", 3'd4, 32'd0);
    tick();

    // byte enables
    avl_wr(3'd2, 32'h0000_01FF, 4'b0001);
    check_reg("be_base_lo", 3'd2, 32'h0FF);
    avl_wr(3'd2, 32'h0000_0100, 4'b0010);
    check_reg("be_base_hi", 3'd2, 32'h1FF);
    avl_wr(3'd3, 32'h0000_03FF, 4'b0000);
    check_reg("be_len_none", 3'd3, 32'h0);
    check_reg("unmapped", 3'd6, 32'h0);

    // test 1: BASE=0 LEN=4, exact latency
    bb = beat_data.size();
    avl_wr(3'd2, 32'd0, 4'hF);
    avl_wr(3'd3, 32'd4, 4'hF);
    avl_wr(3'd0, 32'h5, 4'hF);
    check("t1_rd_c1", {31'd0, MEM_RD}, 32'd1);
    check("t1_addr_c1", {23'd0, MEM_ADDR}, 32'd0);
    check_reg("t1_busy", 3'd1, 32'h1);
    tick();
    check("t1_rd_c2", {31'd0, MEM_RD}, 32'd1);
    check("t1_addr_c2", {23'd0, MEM_ADDR}, 32'd1);
    check("t1_valid_c2", {31'd0, OUT_VALID}, 32'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      if (i != 0) tick();
      check("t1_valid", {31'd0, OUT_VALID}, 32'd1);
      check("t1_data", OUT_DATA, 32'h100 + 32'(i));
      check("t1_last", {31'd0, OUT_LAST}, (i == 3) ? 32'd1 : 32'd0);
    end
    tick(); tick(); tick();
    check_reg("t1_status", 3'd1, 32'h2);
    check_reg("t1_count", 3'd4, 32'd4);
    check("t1_irq", {31'd0, IRQ}, 32'd1);
    check("t1_nbeats", beat_data.size() - bb, 4);

    // test 2: stall after two beats
    avl_wr(3'd1, 32'h2, 4'hF);
    check("t2_irq_clr", {31'd0, IRQ}, 32'd0);
    bb = beat_data.size();
    r0 = rd_cnt;
    avl_wr(3'd2, 32'd10, 4'hF);
    avl_wr(3'd3, 32'd8, 4'hF);
    avl_wr(3'd0, 32'h1, 4'hF);
    wait_beats("t2_wait2", bb, 2, 20);
    OUT_READY = 1'b0;
    tick(); tick();
    check("t2_stall_rd", {31'd0, MEM_RD}, 32'd0);
    check("t2_stall_valid", {31'd0, OUT_VALID}, 32'd1);
    check("t2_held_reads", rd_cnt - r0, 4);
    for (int i = 0; i < 3; i++) begin
      check("t2_stall_data", OUT_DATA, 32'h10C);
      check("t2_stall_rd_loop", {31'd0, MEM_RD}, 32'd0);
      tick();
    end
    OUT_READY = 1'b1;
    wait_beats("t2_wait8", bb, 8, 40);
    check_run("t2", bb, 8, 32'h10A);
    wait_idle("t2_idle", 20);
    check("t2_reads", rd_cnt - r0, 8);
    check_reg("t2_count", 3'd4, 32'd8);
    avl_wr(3'd1, 32'h2, 4'hF);
    check_reg("t2_done_w1c", 3'd1, 32'h0);

    // test 3: bad ranges and the exact upper boundary
    r0 = rd_cnt;
    avl_wr(3'd2, 32'd398, 4'hF);
    avl_wr(3'd3, 32'd4, 4'hF);
    avl_wr(3'd0, 32'h1, 4'hF);
    check("t3_no_rd", {31'd0, MEM_RD}, 32'd0);
    check_reg("t3_err", 3'd1, 32'h4);
    tick();
    check_reg("t3_err_hold", 3'd1, 32'h4);
    avl_wr(3'd1, 32'h4, 4'hF);
    check_reg("t3_err_w1c", 3'd1, 32'h0);
    avl_wr(3'd2, 32'd0, 4'hF);
    avl_wr(3'd3, 32'd0, 4'hF);
    avl_wr(3'd0, 32'h1, 4'hF);
    check_reg("t3_len0_err", 3'd1, 32'h4);
    tick(); tick();
    check("t3_no_reads", rd_cnt - r0, 0);
    avl_wr(3'd1, 32'h4, 4'hF);
    bb = beat_data.size();
    avl_wr(3'd2, 32'd399, 4'hF);
    avl_wr(3'd3, 32'd1, 4'hF);
    avl_wr(3'd0, 32'h1, 4'hF);
    wait_beats("t3_edge_wait", bb, 1, 20);
    check_run("t3_edge", bb, 1, 32'h100 + 32'd399);
    wait_idle("t3_edge_idle", 20);
    check_reg("t3_edge_status", 3'd1, 32'h2);

    // test 4: abort after two beats, then a clean run
    avl_wr(3'd1, 32'hF, 4'hF);
    bb = beat_data.size();
    avl_wr(3'd2, 32'd20, 4'hF);
    avl_wr(3'd3, 32'd6, 4'hF);
    avl_wr(3'd0, 32'h1, 4'hF);
    wait_beats("t4_wait2", bb, 2, 20);
    OUT_READY = 1'b0;
    tick();
    avl_wr(3'd0, 32'h2, 4'hF);
    check("t4_valid", {31'd0, OUT_VALID}, 32'd0);
    check("t4_rd", {31'd0, MEM_RD}, 32'd0);
    check_reg("t4_status", 3'd1, 32'h8);
    check_reg("t4_count", 3'd4, 32'd2);
    r0 = rd_cnt;
    OUT_READY = 1'b1;
    tick(); tick(); tick();
    check("t4_no_beats", beat_data.size() - bb, 2);
    check("t4_no_reads", rd_cnt - r0, 0);
    bb = beat_data.size();
    avl_wr(3'd2, 32'd0, 4'hF);
    avl_wr(3'd3, 32'd3, 4'hF);
    avl_wr(3'd0, 32'h1, 4'hF);
    wait_beats("t4_rerun_wait", bb, 3, 20);
    check_run("t4_rerun", bb, 3, 32'h100);
    wait_idle("t4_rerun_idle", 20);
    check_reg("t4_rerun_status", 3'd1, 32'h2);
    check_reg("t4_rerun_count", 3'd4, 32'd3);

    // test 5: START/BASE/LEN writes while busy are ignored
    avl_wr(3'd1, 32'h2, 4'hF);
    bb = beat_data.size();
    avl_wr(3'd2, 32'd40, 4'hF);
    avl_wr(3'd3, 32'd5, 4'hF);
    avl_wr(3'd0, 32'h5, 4'hF);
    avl_wr(3'd2, 32'd100, 4'hF);
    avl_wr(3'd3, 32'd2, 4'hF);
    avl_wr(3'd0, 32'h5, 4'hF);
    check_reg("t5_base_kept", 3'd2, 32'd40);
    check_reg("t5_len_kept", 3'd3, 32'd5);
    wait_beats("t5_wait", bb, 5, 30);
    wait_idle("t5_idle", 20);
    tick(); tick(); tick();
    check("t5_nbeats", beat_data.size() - bb, 5);
    check_run("t5", bb, 5, 32'h128);
    check_reg("t5_status", 3'd1, 32'h2);
    check("t5_irq", {31'd0, IRQ}, 32'd1);
    avl_wr(3'd1, 32'h2, 4'hF);
    check_reg("t5_status_clr", 3'd1, 32'h0);
    check("t5_irq_clr", {31'd0, IRQ}, 32'd0);

    // test 6: reset mid-run
    bb = beat_data.size();
    avl_wr(3'd2, 32'd0, 4'hF);
    avl_wr(3'd3, 32'd8, 4'hF);
    avl_wr(3'd0, 32'h5, 4'hF);
    tick(); tick();
    check("t6_pre_valid", {31'd0, OUT_VALID}, 32'd1);
    RESET = 1'b1;
    tick();
    check("t6_rd", {31'd0, MEM_RD}, 32'd0);
    check("t6_valid", {31'd0, OUT_VALID}, 32'd0);
    check("t6_data", OUT_DATA, 32'd0);
    check("t6_last", {31'd0, OUT_LAST}, 32'd0);
    check("t6_irq", {31'd0, IRQ}, 32'd0);
    check_reg("t6_ctrl", 3'd0, 32'd0);
    check_reg("t6_status", 3'd1, 32'd0);
    check_reg("t6_base", 3'd2, 32'd0);
    check_reg("t6_len", 3'd3, 32'd0);
    check_reg("t6_count", 3'd4, 32'd0);
    RESET = 1'b0;
    bb = beat_data.size();
    r0 = rd_cnt;
    for (int i = 0; i < 5; i++) tick();
    check("t6_no_beats", beat_data.size() - bb, 0);
    check("t6_no_reads", rd_cnt - r0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
